lut_builder_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-register ternary-LUT preprocessor.
- Accepts one signed activation triple (act0, act1, act2) per handshake.
- Forms all 16 ternary-weight partial-sum LUT entries and narrows them to OUT_W bits, by saturation or by wrap (mode per vector).
- Delivers the entries over a valid/ready interface to the CiM LUT array, reporting per-entry overflow and a running overflow count.
- Sits between the activation buffer and the LUT-based BitNet MAC array.

---
 rtl/lut_builder_pipe_if.sv | 36 +++
 rtl/lut_builder_pipe.sv | 109 ++++++++++
 tb/tb_lut_builder_pipe.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_builder_pipe_if.sv
// ----------------------------------------------------------------------------
// lut_builder_pipe_if : activation-in / LUT-vector-out handshake bundle
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface lut_builder_pipe_if #(
    parameter int ACT_W = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
);
    logic                    in_valid_i;
    logic                    in_ready_o;
    logic signed [ACT_W-1:0] act0_i;
    logic signed [ACT_W-1:0] act1_i;
    logic signed [ACT_W-1:0] act2_i;
    logic                    sat_en_i;
    logic                    out_valid_o;
    logic                    out_ready_i;
    logic [16*OUT_W-1:0]     lut_o;
    logic [15:0]             ovf_o;
    logic [CNT_W-1:0]        ovf_cnt_o;
    logic                    clr_cnt_i;

    modport slave (
        input  in_valid_i, act0_i, act1_i, act2_i, sat_en_i, out_ready_i, clr_cnt_i,
        output in_ready_o, out_valid_o, lut_o, ovf_o, ovf_cnt_o
    );

    modport master (
        output in_valid_i, act0_i, act1_i, act2_i, sat_en_i, out_ready_i, clr_cnt_i,
        input  in_ready_o, out_valid_o, lut_o, ovf_o, ovf_cnt_o
    );
endinterface

`default_nettype wire

// File: rtl/lut_builder_pipe.sv
// ----------------------------------------------------------------------------
// lut_builder_pipe : two-stage ternary-weight LUT builder (exact sums, then
//                    saturate/wrap narrowing) with overflow accounting
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module lut_builder_pipe #(
    parameter int ACT_W = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
) (
    input  wire logic         clk,
    input  wire logic         rst_i,
    lut_builder_pipe_if.slave bus
);
    localparam int SW = ACT_W + 2;
    localparam logic [OUT_W-1:0] c_MAX = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] c_MIN = {1'b1, {(OUT_W-1){1'b0}}};

    logic signed [SW-1:0] w_a0, w_a1, w_a2;
    logic signed [SW-1:0] w_sum [16];
    logic signed [SW-1:0] r_s1_sum [16];
    logic                 r_s1_sat;
    logic                 r_s1_valid;
    logic [16*OUT_W-1:0]  w_lut;
    logic [15:0]          w_ovf;
    logic [16*OUT_W-1:0]  r_lut;
    logic [15:0]          r_ovf;
    logic                 r_s2_valid;
    logic [CNT_W-1:0]     r_cnt;
    logic                 w_s2_adv;
    logic                 w_in_ready;
    logic                 w_out_hs;

    assign w_a0 = {{2{bus.act0_i[ACT_W-1]}}, bus.act0_i};
    assign w_a1 = {{2{bus.act1_i[ACT_W-1]}}, bus.act1_i};
    assign w_a2 = {{2{bus.act2_i[ACT_W-1]}}, bus.act2_i};

    // Balanced-ternary digits of k give the weights; entries 14/15 have no digit form.
    for (genvar k = 0; k < 16; k++) begin : g_entry
        if (k < 14) begin : g_live
            localparam int c_W2 = ((k + 1) % 3) - 1;
            localparam int c_W1 = ((((k - c_W2) / 3) + 1) % 3) - 1;
            localparam int c_W0 = (k - c_W2 - 3 * c_W1) / 9;
            logic signed [SW-1:0] w_t0, w_t1, w_t2;
            assign w_t0 = (c_W0 == 1) ? w_a0 : (c_W0 == -1) ? -w_a0 : '0;
            assign w_t1 = (c_W1 == 1) ? w_a1 : (c_W1 == -1) ? -w_a1 : '0;
            assign w_t2 = (c_W2 == 1) ? w_a2 : (c_W2 == -1) ? -w_a2 : '0;
            assign w_sum[k] = w_t0 + w_t1 + w_t2;
        end else begin : g_zero
            assign w_sum[k] = '0;
        end

        // In range iff every bit from the OUT_W sign bit upward agrees.
        logic [SW-OUT_W:0] w_top;
        assign w_top    = r_s1_sum[k][SW-1:OUT_W-1];
        assign w_ovf[k] = ~((&w_top) | ~(|w_top));
        assign w_lut[k*OUT_W +: OUT_W] = (w_ovf[k] && r_s1_sat)
                                       ? (r_s1_sum[k][SW-1] ? c_MIN : c_MAX)
                                       : r_s1_sum[k][OUT_W-1:0];
    end

    assign w_s2_adv       = ~r_s2_valid | bus.out_ready_i;
    assign w_in_ready     = ~r_s1_valid | w_s2_adv;
    assign w_out_hs       = r_s2_valid & bus.out_ready_i;
    assign bus.in_ready_o = w_in_ready & ~rst_i;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            r_s1_valid <= 1'b0;
            r_s1_sat   <= 1'b0;
            for (int i = 0; i < 16; i++) r_s1_sum[i] <= '0;
            r_s2_valid <= 1'b0;
            r_lut      <= '0;
            r_ovf      <= '0;
            r_cnt      <= '0;
        end else begin
            if (w_in_ready) begin
                r_s1_valid <= bus.in_valid_i;
            end
            if (w_in_ready && bus.in_valid_i) begin
                r_s1_sat <= bus.sat_en_i;
                for (int i = 0; i < 16; i++) r_s1_sum[i] <= w_sum[i];
            end
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
            end
            if (w_s2_adv && r_s1_valid) begin
                r_lut <= w_lut;
                r_ovf <= w_ovf;
            end
            // A clear wins over a same-cycle overflow event, which is then lost.
            if (bus.clr_cnt_i) begin
                r_cnt <= '0;
            end else if (w_out_hs && (|r_ovf) && !(&r_cnt)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign bus.out_valid_o = r_s2_valid;
    assign bus.lut_o       = r_lut;
    assign bus.ovf_o       = r_ovf;
    assign bus.ovf_cnt_o   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lut_builder_pipe.sv
// ----------------------------------------------------------------------------
// tb_lut_builder_pipe : scoreboard bench for lut_builder_pipe (CNT_W=16 and 2)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_lut_builder_pipe;
    localparam int ACT_W = 32;
    localparam int OUT_W = 16;
    localparam int CNT_W = 16;
    localparam int W0 [14] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    localparam int W1 [14] = '{0, 0, 1, 1, 1,-1,-1,-1, 0, 0, 0, 1, 1, 1};
    localparam int W2 [14] = '{0, 1,-1, 0, 1,-1, 0, 1,-1, 0, 1,-1, 0, 1};

    typedef struct packed {
        logic [16*OUT_W-1:0] lut;
        logic [15:0]         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    lut_builder_pipe_if #(.ACT_W(ACT_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) bus ();
    lut_builder_pipe_if #(.ACT_W(ACT_W), .OUT_W(OUT_W), .CNT_W(2))     bus2 ();

    lut_builder_pipe #(.ACT_W(ACT_W), .OUT_W(OUT_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_i(rst), .bus(bus.slave)
    );
    lut_builder_pipe #(.ACT_W(ACT_W), .OUT_W(OUT_W), .CNT_W(2)) dut2 (
        .clk(clk), .rst_i(rst), .bus(bus2.slave)
    );

    assign bus2.in_valid_i  = bus.in_valid_i;
    assign bus2.act0_i      = bus.act0_i;
    assign bus2.act1_i      = bus.act1_i;
    assign bus2.act2_i      = bus.act2_i;
    assign bus2.sat_en_i    = bus.sat_en_i;
    assign bus2.out_ready_i = bus.out_ready_i;
    assign bus2.clr_cnt_i   = bus.clr_cnt_i;

    int   n_pass = 0;
    int   n_chk  = 0;
    exp_t q[$];
    int   cnt_m  = 0;
    int   cnt2_m = 0;
    bit   prev_rst = 1'b0;
    bit   last_ihs;
    int   n_out = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
        n_chk++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    task automatic chk_e(input string tag, input int k, input int expv);
        logic [OUT_W-1:0] ev;
        ev = OUT_W'(expv);
        chk(tag, 256'(bus.lut_o[k*OUT_W +: OUT_W]), 256'(ev));
    endtask

    function automatic exp_t model(input longint a0, input longint a1, input longint a2, input bit sat);
        exp_t   e;
        longint s, r;
        longint hi, lo;
        hi = (longint'(1) <<< (OUT_W - 1)) - 1;
        lo = -hi - 1;
        e  = '0;
        for (int k = 0; k < 14; k++) begin
            s = W0[k] * a0 + W1[k] * a1 + W2[k] * a2;
            r = s;
            if (s > hi || s < lo) begin
                e.ovf[k] = 1'b1;
                if (sat) r = (s > hi) ? hi : lo;
            end
            e.lut[k*OUT_W +: OUT_W] = r[OUT_W-1:0];
        end
        return e;
    endfunction

    // Samples 1 time unit into the cycle, then advances to 1 unit past the next edge.
    task automatic cyc();
        bit   ihs, ohs, hit;
        exp_t e;
        #1;
        ihs = bus.in_valid_i && bus.in_ready_o;
        ohs = bus.out_valid_o && bus.out_ready_i;
        hit = 1'b0;
        chk("ovf_cnt", 256'(bus.ovf_cnt_o), 256'(cnt_m));
        chk("ovf_cnt_w2", 256'(bus2.ovf_cnt_o), 256'(cnt2_m));
        if (rst) begin
            chk("rst_in_ready", 256'(bus.in_ready_o), 256'(0));
            if (prev_rst) chk("rst_out_valid", 256'(bus.out_valid_o), 256'(0));
            q.delete();
            cnt_m  = 0;
            cnt2_m = 0;
            ihs    = 1'b0;
        end else begin
            if (ohs) begin
                n_out++;
                if (q.size() == 0) begin
                    chk("unexpected_out", 256'(0), 256'(1));
                end else begin
                    e   = q.pop_front();
                    hit = |e.ovf;
                    chk("lut", 256'(bus.lut_o), 256'(e.lut));
                    chk("ovf", 256'(bus.ovf_o), 256'(e.ovf));
                    chk("lut_w2", 256'(bus2.lut_o), 256'(e.lut));
                end
            end
            if (ihs) q.push_back(model(longint'(bus.act0_i), longint'(bus.act1_i),
                                       longint'(bus.act2_i), bus.sat_en_i));
            if (bus.clr_cnt_i) begin
                cnt_m  = 0;
                cnt2_m = 0;
            end else if (ohs && hit) begin
                if (cnt_m < 65535) cnt_m++;
                if (cnt2_m < 3)    cnt2_m++;
            end
        end
        prev_rst = rst;
        last_ihs = ihs;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int a0, input int a1, input int a2, input bit sat);
        bus.in_valid_i = 1'b1;
        bus.act0_i     = a0;
        bus.act1_i     = a1;
        bus.act2_i     = a2;
        bus.sat_en_i   = sat;
    endtask

    task automatic drain();
        bus.in_valid_i  = 1'b0;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) cyc();
        chk("drain_timeout", 256'(q.size()), 256'(0));
    endtask

    // Pushes one vector through and returns once its handshake is done.
    task automatic send(input int a0, input int a1, input int a2, input bit sat);
        int c;
        drive(a0, a1, a2, sat);
        c = 0;
        do begin cyc(); c++; end while (!last_ihs && c < 20);
        chk("send_timeout", 256'(last_ihs), 256'(1));
        bus.in_valid_i = 1'b0;
    endtask

    int acc;
    int outs0;

    initial begin
        rst             = 1'b1;
        bus.in_valid_i  = 1'b0;
        bus.act0_i      = '0;
        bus.act1_i      = '0;
        bus.act2_i      = '0;
        bus.sat_en_i    = 1'b0;
        bus.out_ready_i = 1'b1;
        bus.clr_cnt_i   = 1'b0;
        @(posedge clk);
        #1;
        cyc();
        cyc();
        chk("rst_lut", 256'(bus.lut_o), 256'(0));
        chk("rst_ovf", 256'(bus.ovf_o), 256'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 256'(bus.in_ready_o), 256'(1));

        // Basic vector and two-cycle latency
        send(100, 20, 3, 1'b1);
        chk("lat_1", 256'(bus.out_valid_o), 256'(0));
        cyc();
        chk("lat_2", 256'(bus.out_valid_o), 256'(1));
        chk_e("e1", 1, 3);   chk_e("e2", 2, 17);   chk_e("e3", 3, 20);
        chk_e("e5", 5, 77);  chk_e("e9", 9, 100);  chk_e("e11", 11, 117);
        chk_e("e13", 13, 123); chk_e("e0", 0, 0); chk_e("e14", 14, 0); chk_e("e15", 15, 0);
        chk("basic_ovf", 256'(bus.ovf_o), 256'(0));
        cyc();

        // Positive overflow, saturate then wrap
        send(30000, 5000, 0, 1'b1);
        cyc();
        chk_e("pos_sat_e12", 12, 32767);
        chk_e("pos_sat_e13", 13, 32767);
        chk_e("pos_e6", 6, 25000);
        chk("pos_ovf_bits", 256'(bus.ovf_o[13:12]), 256'(3));
        cyc();
        chk("cnt_one", 256'(bus.ovf_cnt_o), 256'(1));
        send(30000, 5000, 0, 1'b0);
        cyc();
        chk_e("pos_wrap_e12", 12, -30536);
        cyc();

        // Negative overflow, saturate then wrap
        send(-30000, 5000, 0, 1'b1);
        cyc();
        chk_e("neg_sat_e6", 6, -32768);
        chk_e("neg_sat_e5", 5, -32768);
        chk("neg_ovf_bits", 256'(bus.ovf_o[6:5]), 256'(3));
        cyc();
        send(-30000, 5000, 0, 1'b0);
        cyc();
        chk_e("neg_wrap_e6", 6, 30536);
        cyc();

        // Streaming random vectors, one per cycle
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            drive(int'($urandom_range(0, 80000)) - 40000, int'($urandom_range(0, 80000)) - 40000,
                  int'($urandom_range(0, 80000)) - 40000, 1'(i & 1));
            cyc();
            chk("stream_accept", 256'(last_ihs), 256'(1));
        end
        drain();

        // Backpressure: three offered, two accepted, then released in order
        bus.out_ready_i = 1'b0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            drive(1000 * (acc + 1), -7 * (acc + 1), 40000 + acc, 1'b1);
            cyc();
            if (last_ihs) acc++;
        end
        chk("bp_accepted", 256'(acc), 256'(2));
        chk("bp_in_ready", 256'(bus.in_ready_o), 256'(0));
        outs0 = n_out;
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cyc();
            if (last_ihs) acc++;
            bus.in_valid_i = (acc < 3);
        end
        chk("bp_consecutive", 256'(n_out - outs0), 256'(3));
        drain();

        // Counter: three overflowing, clear collides with the fourth
        bus.clr_cnt_i = 1'b1;
        cyc();
        bus.clr_cnt_i = 1'b0;
        for (int i = 0; i < 3; i++) send(30000, 5000, 0, 1'b1);
        drain();
        chk("cnt_three", 256'(bus.ovf_cnt_o), 256'(3));
        send(30000, 5000, 0, 1'b1);
        cyc();
        bus.clr_cnt_i = 1'b1;
        cyc();
        bus.clr_cnt_i = 1'b0;
        chk("cnt_clr_priority", 256'(bus.ovf_cnt_o), 256'(0));
        for (int i = 0; i < 5; i++) send(-30000, 5000, 0, 1'b0);
        drain();
        cyc();
        chk("cnt_five", 256'(bus.ovf_cnt_o), 256'(5));
        chk("cnt_w2_sat", 256'(bus2.ovf_cnt_o), 256'(3));

        // Reset with two vectors buffered
        bus.out_ready_i = 1'b0;
        send(11, 22, 33, 1'b1);
        send(44, 55, 66, 1'b1);
        chk("pre_rst_full", 256'(bus.in_ready_o), 256'(0));
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        bus.out_ready_i = 1'b1;
        outs0 = n_out;
        for (int c = 0; c < 4; c++) cyc();
        chk("no_stale_out", 256'(n_out - outs0), 256'(0));
        chk("post_rst_ready2", 256'(bus.in_ready_o), 256'(1));
        send(-5, 9, 2, 1'b0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
